// File: rtl/floor_request_queue.sv
// floor_request_queue: ordered store of pending elevator floor requests.
// Two request sources (hall button wins over cabin switch), tail or urgent
// head insertion, duplicate suppression/promotion, head exposed as target.
module floor_request_queue #(
  parameter int FLOOR_W = 2,
  parameter int DEPTH   = 10,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_valid,
  input  logic [FLOOR_W-1:0] btn_floor,
  input  logic               btn_urgent,
  output logic               btn_ready,
  input  logic               sw_valid,
  input  logic [FLOOR_W-1:0] sw_floor,
  input  logic               sw_urgent,
  output logic               sw_ready,
  input  logic               pop,
  output logic               head_valid,
  output logic [FLOOR_W-1:0] head_floor,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               dup_drop,
  output logic               underflow
);

  logic [FLOOR_W-1:0] floor_q   [DEPTH];
  logic [FLOOR_W-1:0] floor_d   [DEPTH];
  logic [FLOOR_W-1:0] post_pop  [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d, cnt_pp;
  logic               full_q, empty_q, head_valid_q;
  logic               dup_q, dup_d, uf_q, uf_d;

  logic               space, do_pop, push;
  logic [FLOOR_W-1:0] push_floor;
  logic               push_urgent;
  logic               hit;
  logic [CNT_W-1:0]   hit_idx;

  // A slot is available if not full, or if a real pop frees one this edge.
  assign space       = ~full_q | (pop & ~empty_q);
  assign btn_ready   = btn_valid & space;
  assign sw_ready    = sw_valid & ~btn_valid & space;
  assign push        = btn_ready | sw_ready;
  assign push_floor  = btn_valid ? btn_floor  : sw_floor;
  assign push_urgent = btn_valid ? btn_urgent : sw_urgent;
  assign do_pop      = pop & ~empty_q;

  // Contents as seen after the pop half of the edge; pushes apply on top of this.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) post_pop[i] = floor_q[i];
    cnt_pp = count_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) post_pop[i] = floor_q[i + 1];
      post_pop[DEPTH-1] = '0;
      cnt_pp = count_q - CNT_W'(1);
    end
  end

  // Locate a valid post-pop entry holding the requested floor (at most one exists).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_pp) && (post_pop[i] == push_floor)) begin
        hit     = 1'b1;
        hit_idx = CNT_W'(i);
      end
    end
  end

  // Apply the accepted push: tail append, head insert, or duplicate merge/promotion.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) floor_d[i] = post_pop[i];
    count_d = cnt_pp;
    dup_d   = 1'b0;
    uf_d    = pop & empty_q;
    if (push) begin
      if (hit) begin
        dup_d = 1'b1;
        if (push_urgent) begin
          // Close the gap left by the matching entry and re-insert it at the head.
          floor_d[0] = push_floor;
          for (int i = 1; i < DEPTH; i++) begin
            if (CNT_W'(i) <= hit_idx) floor_d[i] = post_pop[i - 1];
          end
        end
      end else if (push_urgent) begin
        // Space guarantees the top entry is invalid (zero), so nothing is lost.
        floor_d[0] = push_floor;
        for (int i = 1; i < DEPTH; i++) floor_d[i] = post_pop[i - 1];
        count_d = cnt_pp + CNT_W'(1);
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == cnt_pp) floor_d[i] = push_floor;
        end
        count_d = cnt_pp + CNT_W'(1);
      end
    end
  end

  // State and registered status flags; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) floor_q[i] <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      head_valid_q <= 1'b0;
      dup_q        <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) floor_q[i] <= floor_d[i];
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(DEPTH));
      empty_q      <= (count_d == '0);
      head_valid_q <= (count_d != '0);
      dup_q        <= dup_d;
      uf_q         <= uf_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_floor = floor_q[0];
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign dup_drop   = dup_q;
  assign underflow  = uf_q;

endmodule
